// File: rtl/hold_counter_sat.sv
// Saturating hold counter: long-press flag, ceiling, optional auto-repeat.
// Optional feature macro: HOLD_COUNTER_REPEAT_EN (auto-repeat strobes).
module hold_counter_sat #(
  parameter int WIDTH        = 3,
  parameter int THRESH       = 4,
  parameter int MAX          = 7,
  parameter int REPEAT_TICKS = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             long_press,
  output logic             long_pulse,
  output logic             saturated,
  output logic             repeat_pulse
);

  if (!(THRESH >= 1 && THRESH <= MAX &&
        MAX <= (1 << WIDTH) - 1 &&
        REPEAT_TICKS >= 1)) begin : g_bad_cfg
    $error("hold_counter_sat: illegal parameter set");
  end

  localparam logic [WIDTH-1:0] THR_V = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_d;
  logic             long_press_d;
  logic             long_pulse_d;
  logic             saturated_d;

  // Next count; flags derived from it so they land on the same edge.
  always_comb begin
    count_d = count;
    if (!clear_n || !hold) begin
      count_d = '0;
    end else if (en && count < MAX_V) begin
      count_d = count + WIDTH'(1);
    end
    long_press_d = (count_d >= THR_V);
    saturated_d  = (count_d == MAX_V);
    long_pulse_d = (count_d == THR_V) &&
                   (count != THR_V);
  end

  // Registered count and flags with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count      <= '0;
      long_press <= 1'b0;
      long_pulse <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      count      <= count_d;
      long_press <= long_press_d;
      long_pulse <= long_pulse_d;
      saturated  <= saturated_d;
    end
  end

`ifdef HOLD_COUNTER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RT_M1 =
    RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_q;
  logic [RW-1:0] rep_d;
  logic          rpt_d;

  // Repeat tick counter runs only while already saturated and held.
  always_comb begin
    rep_d = rep_q;
    rpt_d = 1'b0;
    if (!clear_n || !hold || !saturated) begin
      rep_d = '0;
    end else if (en) begin
      if (rep_q == RT_M1) begin
        rep_d = '0;
        rpt_d = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  // Repeat counter and strobe registers.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      rep_q        <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_q        <= rep_d;
      repeat_pulse <= rpt_d;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_hold_counter_sat.sv
// Directed bench for hold_counter_sat (default and THRESH==MAX configs).
// Repeat checks follow HOLD_COUNTER_REPEAT_EN when defined.
module tb_hold_counter_sat;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       en = 1'b0;
  logic       hold = 1'b0;

  logic [2:0] c0;
  logic       lp0, pl0, st0, rp0;
  logic [3:0] c1;
  logic       lp1, pl1, st1, rp1;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hold_counter_sat u0 (
    .clk(clk), .clear_n(clear_n), .en(en), .hold(hold),
    .count(c0), .long_press(lp0), .long_pulse(pl0),
    .saturated(st0), .repeat_pulse(rp0)
  );

  hold_counter_sat #(
    .WIDTH(4), .THRESH(9), .MAX(9), .REPEAT_TICKS(2)
  ) u1 (
    .clk(clk), .clear_n(clear_n), .en(en), .hold(hold),
    .count(c1), .long_press(lp1), .long_pulse(pl1),
    .saturated(st1), .repeat_pulse(rp1)
  );

  task automatic step(input logic c, input logic h,
                      input logic e);
    @(negedge clk);
    clear_n = c;
    hold    = h;
    en      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] b(input bit v);
    return {31'd0, v};
  endfunction

  initial begin
    // reset state
    step(1'b0, 1'b0, 1'b0);
    chk("rst count", c0, 0);
    chk("rst lpress", b(lp0), 0);
    chk("rst lpulse", b(pl0), 0);
    chk("rst sat", b(st0), 0);
    chk("rst rpt", b(rp0), 0);

    // continuous en: 1..7 then saturated
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("t1 count", c0, i);
      chk("t1 lpress", b(lp0), b(i >= 4));
      chk("t1 lpulse", b(pl0), b(i == 4));
      chk("t1 sat", b(st0), b(i == 7));
      chk("t1 rpt", b(rp0), 0);
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("t1 hold7", c0, 7);
      chk("t1 lpulse0", b(pl0), 0);
      chk("t1 sat1", b(st0), 1);
`ifdef HOLD_COUNTER_REPEAT_EN
      chk("t6 rpt", b(rp0), b(k % 2 == 0));
`else
      chk("t6 rpt off", b(rp0), 0);
`endif
    end
    // release stops repeats
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("t6 rel count", c0, 0);
      chk("t6 rel sat", b(st0), 0);
      chk("t6 rel rpt", b(rp0), 0);
      chk("t6 rel pulse", b(pl0), 0);
    end

    // en strobing every third cycle
    step(1'b0, 1'b1, 1'b1);
    chk("t2 rst prio", c0, 0);
    for (int s = 1; s <= 6; s++) begin
      for (int g = 0; g < 2; g++) begin
        step(1'b1, 1'b1, 1'b0);
        chk("t2 idle count", c0, s - 1);
        chk("t2 idle pulse", b(pl0), 0);
      end
      step(1'b1, 1'b1, 1'b1);
      chk("t2 count", c0, s);
      chk("t2 pulse", b(pl0), b(s == 4));
      chk("t2 lpress", b(lp0), b(s >= 4));
    end

    // release at 3 then re-press
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b1, 1'b1);
    chk("t3 at3", c0, 3);
    step(1'b1, 1'b0, 1'b1);
    chk("t3 rel count", c0, 0);
    chk("t3 rel pulse", b(pl0), 0);
    chk("t3 rel lpress", b(lp0), 0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("t3 re count", c0, i);
      chk("t3 re pulse", b(pl0), b(i == 4));
    end

    // mid-count reset at 5
    step(1'b1, 1'b1, 1'b1);
    chk("t4 at5", c0, 5);
    step(1'b0, 1'b1, 1'b1);
    chk("t4 count", c0, 0);
    chk("t4 lpress", b(lp0), 0);
    chk("t4 lpulse", b(pl0), 0);
    chk("t4 sat", b(st0), 0);
    chk("t4 rpt", b(rp0), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("t4 resume1", c0, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("t4 resume2", c0, 2);

    // THRESH == MAX == 9, WIDTH 4
    step(1'b0, 1'b0, 1'b0);
    chk("t5 rst", c1, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("t5 count", c1, i);
      chk("t5 lpress", b(lp1), b(i == 9));
      chk("t5 lpulse", b(pl1), b(i == 9));
      chk("t5 sat", b(st1), b(i == 9));
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("t5 nowrap", c1, 9);
      chk("t5 pulse0", b(pl1), 0);
      chk("t5 sat1", b(st1), 1);
      chk("t5 lpress1", b(lp1), 1);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, errors);
    $finish;
  end

endmodule
